// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and parity helper for the UART echo core.
// Imported by uart_fifo and uart_echo_core.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  localparam logic [3:0] SUB_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] SUB_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Parity bit that makes the frame satisfy the chosen mode.
  // Zero-padding the word does not change the XOR reduction.
  function automatic logic par_bit(
    input logic [7:0] d,
    input int         mode
  );
    return (mode == PAR_EVEN) ? ^d : ~^d;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead synchronous FIFO holding received words awaiting echo.
// Ports: push/wdata in, pop/rdata out, full, empty, count (occupancy).
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A push into a full FIFO is accepted only when a pop frees
  // the slot in the same cycle.
  assign w_do_push = push & (~w_full | pop);
  assign w_do_pop  = pop & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_do_push)
                         - CW'(w_do_pop);
    end
  end

  assign rdata = r_mem[r_rptr];
  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;

endmodule

// File: rtl/uart_echo_core.sv
// UART transceiver with 16x oversampled RX, parity, FIFO echo to TX.
// Ports: rxd/txd serial, echo_en, cts_n, rx_valid/rx_data/errors, overflow, idle, fifo_count.
module uart_echo_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV    = 326,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          echo_en,
  input  logic                          cts_n,
  output logic                          txd,
  output logic                          rx_valid,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          dataerror,
  output logic                          framerror,
  output logic                          overflow,
  output logic                          idle,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY_MODE != PAR_NONE);

  // Oversample tick
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // RX synchronizer
  logic r_sync1;
  logic r_sync2;
  logic w_rx;

  assign w_rx = r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // RX FSM
  rx_state_t            r_rx_state;
  logic [3:0]           r_rx_sub;
  logic [2:0]           r_rx_bitcnt;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 r_rx_armed;
  logic                 r_rx_valid;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_dataerror;
  logic                 r_framerror;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state  <= RX_IDLE;
      r_rx_sub    <= '0;
      r_rx_bitcnt <= '0;
      r_rx_shift  <= '0;
      r_rx_par    <= 1'b0;
      r_rx_armed  <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_dataerror <= 1'b0;
      r_framerror <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      // Line must be seen high before a low is taken as a start
      // bit; both sync stages are checked so reset values of the
      // synchronizer cannot arm the receiver on their own.
      if (w_tick && r_sync1 && r_sync2) r_rx_armed <= 1'b1;
      if (w_tick) begin
        unique case (r_rx_state)
          RX_IDLE: begin
            if (r_rx_armed && !w_rx) begin
              r_rx_state <= RX_START;
              r_rx_sub   <= '0;
            end
          end
          RX_START: begin
            if (r_rx_sub == SUB_MID) begin
              r_rx_sub <= '0;
              if (w_rx) begin
                r_rx_state <= RX_IDLE;
              end else begin
                r_rx_state  <= RX_DATA;
                r_rx_bitcnt <= '0;
              end
            end else begin
              r_rx_sub <= r_rx_sub + 4'd1;
            end
          end
          RX_DATA: begin
            if (r_rx_sub == SUB_LAST) begin
              r_rx_sub    <= '0;
              r_rx_shift  <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
              r_rx_bitcnt <= r_rx_bitcnt + 3'd1;
              if (r_rx_bitcnt == BIT_LAST)
                r_rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
            end else begin
              r_rx_sub <= r_rx_sub + 4'd1;
            end
          end
          RX_PARITY: begin
            if (r_rx_sub == SUB_LAST) begin
              r_rx_sub   <= '0;
              r_rx_par   <= w_rx;
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_sub <= r_rx_sub + 4'd1;
            end
          end
          RX_STOP: begin
            if (r_rx_sub == SUB_LAST) begin
              r_rx_sub    <= '0;
              r_rx_state  <= RX_IDLE;
              r_rx_valid  <= 1'b1;
              r_rx_data   <= r_rx_shift;
              r_framerror <= ~w_rx;
              r_dataerror <= HAS_PAR &&
                (r_rx_par != par_bit(8'(r_rx_shift),
                                     PARITY_MODE));
              // A low stop bit leaves the line low; wait for it
              // to go high before hunting for the next start.
              if (!w_rx) r_rx_armed <= 1'b0;
            end else begin
              r_rx_sub <= r_rx_sub + 4'd1;
            end
          end
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // Echo FIFO
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_rdata;
  logic [CW-1:0]        w_count;

  tx_state_t r_tx_state;

  assign w_push = r_rx_valid & echo_en
                & ~r_dataerror & ~r_framerror;
  assign w_pop  = (r_tx_state == TX_IDLE)
                & ~w_empty & ~cts_n;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (r_rx_data),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // TX FSM
  logic [3:0]           r_tx_sub;
  logic [2:0]           r_tx_bitcnt;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx_stopcnt;
  logic                 r_txd;
  logic                 r_idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state   <= TX_IDLE;
      r_tx_sub     <= '0;
      r_tx_bitcnt  <= '0;
      r_tx_shift   <= '0;
      r_tx_par     <= 1'b0;
      r_tx_stopcnt <= 1'b0;
      r_txd        <= 1'b1;
      r_idle       <= 1'b1;
    end else begin
      r_idle <= (r_tx_state == TX_IDLE) && (w_count == '0);
      unique case (r_tx_state)
        TX_IDLE: begin
          if (w_pop) begin
            r_tx_state <= TX_START;
            r_tx_sub   <= '0;
            r_tx_shift <= w_rdata;
            r_tx_par   <= par_bit(8'(w_rdata), PARITY_MODE);
            r_txd      <= 1'b0;
          end
        end
        TX_START: begin
          if (w_tick) begin
            if (r_tx_sub == SUB_LAST) begin
              r_tx_sub    <= '0;
              r_tx_bitcnt <= '0;
              r_tx_state  <= TX_DATA;
              r_txd       <= r_tx_shift[0];
            end else begin
              r_tx_sub <= r_tx_sub + 4'd1;
            end
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            if (r_tx_sub == SUB_LAST) begin
              r_tx_sub <= '0;
              if (r_tx_bitcnt == BIT_LAST) begin
                if (HAS_PAR) begin
                  r_tx_state <= TX_PARITY;
                  r_txd      <= r_tx_par;
                end else begin
                  r_tx_state   <= TX_STOP;
                  r_tx_stopcnt <= 1'b0;
                  r_txd        <= 1'b1;
                end
              end else begin
                r_tx_bitcnt <= r_tx_bitcnt + 3'd1;
                r_tx_shift  <= r_tx_shift >> 1;
                r_txd       <= r_tx_shift[1];
              end
            end else begin
              r_tx_sub <= r_tx_sub + 4'd1;
            end
          end
        end
        TX_PARITY: begin
          if (w_tick) begin
            if (r_tx_sub == SUB_LAST) begin
              r_tx_sub     <= '0;
              r_tx_state   <= TX_STOP;
              r_tx_stopcnt <= 1'b0;
              r_txd        <= 1'b1;
            end else begin
              r_tx_sub <= r_tx_sub + 4'd1;
            end
          end
        end
        TX_STOP: begin
          if (w_tick) begin
            if (r_tx_sub == SUB_LAST) begin
              r_tx_sub <= '0;
              if (r_tx_stopcnt == STOP_LAST)
                r_tx_state <= TX_IDLE;
              else
                r_tx_stopcnt <= 1'b1;
            end else begin
              r_tx_sub <= r_tx_sub + 4'd1;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign txd        = r_txd;
  assign rx_valid   = r_rx_valid;
  assign rx_data    = r_rx_data;
  assign dataerror  = r_dataerror;
  assign framerror  = r_framerror;
  assign overflow   = w_push & w_full & ~w_pop;
  assign idle       = r_idle;
  assign fifo_count = w_count;

endmodule

// File: tb/tb_uart_echo_core.sv
// Scoreboard bench for uart_echo_core: directed frames, RX and TX monitors.
// Expected RX results and TX echoes are queued at stimulus time.
module tb_uart_echo_core;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       echo_en = 1'b1;
  logic       cts_n = 1'b0;
  logic       txd;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       dataerror;
  logic       framerror;
  logic       overflow;
  logic       idle;
  logic [2:0] fifo_count;

  uart_echo_core #(
    .BAUD_DIV    (4),
    .DATA_BITS   (8),
    .PARITY_MODE (1),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .echo_en    (echo_en),
    .cts_n      (cts_n),
    .txd        (txd),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .dataerror  (dataerror),
    .framerror  (framerror),
    .overflow   (overflow),
    .idle       (idle),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_exp_t;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } tx_exp_t;

  rx_exp_t rx_q[$];
  tx_exp_t tx_q[$];

  int         checks = 0;
  int         errors = 0;
  int         rx_cnt = 0;
  int         ovf_cnt = 0;
  int         epoch = 0;
  logic [7:0] ovf_data = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d,
                      input logic p,
                      input logic s,
                      input logic pe,
                      input logic fe,
                      input logic echo);
    rx_exp_t re;
    tx_exp_t te;
    re.d = d; re.pe = pe; re.fe = fe;
    rx_q.push_back(re);
    if (echo) begin
      te.d = d; te.p = p;
      tx_q.push_back(te);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
    drive_bit(1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", idle, 1);
  endtask

  // RX monitor
  always @(negedge clk) begin
    rx_exp_t e;
    if (rst && rx_valid) begin
      rx_cnt++;
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected got %0h want none", rx_data);
      end else begin
        e = rx_q.pop_front();
        chk("rx_data", rx_data, e.d);
        chk("rx_dataerror", dataerror, e.pe);
        chk("rx_framerror", framerror, e.fe);
      end
    end
  end

  always @(negedge clk) begin
    if (overflow === 1'b1) begin
      ovf_cnt++;
      ovf_data = rx_data;
    end
  end

  // TX monitor: decodes frames at bit centres
  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       st;
    int         ep;
    tx_exp_t    e;
    forever begin
      do @(negedge clk); while (txd !== 1'b0);
      ep = epoch;
      repeat (BIT/2) @(negedge clk);
      st = txd;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        d[i] = txd;
      end
      repeat (BIT) @(negedge clk);
      p = txd;
      repeat (BIT) @(negedge clk);
      s = txd;
      if (ep == epoch) begin
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected got %0h want none", d);
        end else begin
          e = tx_q.pop_front();
          chk("tx_start", st, 0);
          chk("tx_data", d, e.d);
          chk("tx_parity", p, e.p);
          chk("tx_stop", s, 1);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_dataerror", dataerror, 0);
    chk("rst_framerror", framerror, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_idle", idle, 1);
    chk("rst_fifo_count", fifo_count, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // good frame with echo
    send(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("good_idle_busy", idle, 0);
    wait_idle(2000);
    chk("good_fifo", fifo_count, 0);
    chk("good_rx_cnt", rx_cnt, 1);

    // parity error, not pushed
    send(8'hA3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1 & 1'b0);
    repeat (10) @(negedge clk);
    chk("perr_fifo", fifo_count, 0);
    chk("perr_txd", txd, 1);
    chk("perr_idle", idle, 1);
    chk("perr_rx_cnt", rx_cnt, 2);

    // frame error then good frame with same data
    send(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ferr_fifo", fifo_count, 0);
    chk("ferr_txd", txd, 1);
    send(8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle(2000);
    chk("ferr_rx_cnt", rx_cnt, 4);

    // false start shorter than half a bit
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    chk("false_start_rx_cnt", rx_cnt, 4);
    chk("false_start_idle", idle, 1);

    // reset while TX is in its data bits
    send(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    chk("tx_busy", idle, 0);
    epoch++;
    tx_q.delete();
    rxd = 1'b0;
    rst = 1'b0;
    #1;
    chk("midtx_rst_txd", txd, 1);
    chk("midtx_rst_idle", idle, 1);
    chk("midtx_rst_fifo", fifo_count, 0);
    chk("midtx_rst_rx_data", rx_data, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    // line held low after reset must not look like a start
    repeat (300) @(negedge clk);
    rxd = 1'b1;
    repeat (400) @(negedge clk);
    chk("held_low_rx_cnt", rx_cnt, 5);
    chk("post_rst_txd", txd, 1);

    // overflow with flow control held off
    cts_n = 1'b1;
    send(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ovf_full_txd", txd, 1);
    send(8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_fifo", fifo_count, 4);
    chk("ovf_pulses", ovf_cnt, 1);
    chk("ovf_data", ovf_data, 8'h05);
    chk("ovf_idle", idle, 0);
    chk("ovf_txd", txd, 1);
    cts_n = 1'b0;
    repeat (BIT * 2) @(negedge clk);
    chk("drain_fifo_dec", fifo_count, 3);
    wait_idle(4000);
    chk("drain_fifo", fifo_count, 0);
    chk("drain_rx_cnt", rx_cnt, 10);

    repeat (100) @(negedge clk);
    chk("rx_q_empty", rx_q.size(), 0);
    chk("tx_q_empty", tx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_core.md
Name: uart_echo_core

Overview:
- Parametrised single-clock UART transceiver with an RX→TX echo path buffered by a FIFO. It is the successor to the fixed 8-bit, derived-clock loopback.
- Baud timing comes from an internal clock-enable tick; no generated clocks.
- Adds configurable data bits, parity (none/odd/even), 1 or 2 stop bits, 16x oversampled receive with false-start rejection, TX flow control, and overflow reporting.

Parameters:
- BAUD_DIV, 326: clk cycles per oversample tick (16 ticks = 1 bit); must be ≥2.
- DATA_BITS, 8: data width, legal 5..8.
- PARITY_MODE, 1: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2 (TX sends this many; RX checks only the first).
- FIFO_DEPTH, 16: echo FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rxd  in  1  serial input, asynchronous.
- echo_en  in  1  1 = push good frames into the FIFO for retransmit.
- cts_n  in  1  0 = TX may start a new frame; sampled only in TX_IDLE.
- txd  out  1  serial output.
- rx_valid  out  1  one-cycle pulse per received frame.
- rx_data  out  DATA_BITS  last received data, LSB-first assembled.
- dataerror  out  1  parity error of last frame.
- framerror  out  1  stop bit was 0 in last frame.
- overflow  out  1  one-cycle pulse: good frame dropped, FIFO full.
- idle  out  1  TX_IDLE and FIFO empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0, async): txd=1, rx_valid=0, rx_data=0, dataerror=0, framerror=0, overflow=0, idle=1, fifo_count=0. Synchronizer flops reset to 1. All FSMs return to IDLE; tick counter=0.
  - Reset mid-frame aborts both directions immediately.
  - After release, RX ignores rxd until it has been seen high for one tick, so a held-low line is not taken as a start bit.
- Tick: counter 0..BAUD_DIV-1; tick=1 for one clk when counter==BAUD_DIV-1, then wraps to 0.
- RX synchronizer: rxd passes through 2 flops; only the synchronized value is used.
- RX FSM: RX_IDLE → RX_START → RX_DATA → RX_PARITY (skipped when PARITY_MODE=0) → RX_STOP → RX_IDLE.
  - RX_IDLE: on a tick with synchronized rxd=0, go to RX_START with subtick=0.
  - RX_START: at subtick 7, if rxd=1 the start is false; return to RX_IDLE with no pulse. Otherwise reset subtick and sample every 16 ticks (bit centres).
  - RX_DATA: DATA_BITS samples, LSB first.
  - Parity:
    - odd: data^parity XOR-reduction must be 1;
    - even: it must be 0;
    - mismatch sets dataerror.
  - RX_STOP: stop sample 0 sets framerror.
  - The cycle after the stop-bit centre tick, rx_valid=1 for exactly one clk. rx_data, dataerror and framerror update in the same cycle and hold until the next rx_valid.
- Push: rx_valid & echo_en & !dataerror & !framerror.
  - Push while FIFO full and no pop in the same cycle: data dropped, overflow=1 for that cycle.
  - Push while full with a simultaneous pop: both happen, count unchanged.
  - Errored frames are never pushed.
- TX FSM: TX_IDLE → TX_START → TX_DATA → TX_PARITY (if enabled) → TX_STOP (STOP_BITS bits) → TX_IDLE. Each bit lasts 16 ticks.
  - In TX_IDLE with FIFO non-empty and cts_n=0: pop, latch the word, and drive txd=0 from the next clk.
  - cts_n is ignored mid-frame.
  - Parity bit: odd = ~^data; even = ^data.
  - Back-to-back frames: a new start can begin the clk after the last stop bit ends.
- idle is registered; it is 1 only when TX_IDLE and fifo_count==0.
- FIFO: show-ahead (data valid when non-empty), pointer wrap modulo FIFO_DEPTH. Pop when empty is impossible by construction.

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - RX/TX state encodings;
  - OVERSAMPLE=16 and the mid-sample index 7.
- One sub-module, uart_fifo (sync FIFO: push, pop, wdata, rdata, full, empty, count; parameters WIDTH, DEPTH).
- RX, TX and tick logic stay in uart_echo_core.

Test Plan:
- Bench parameters for all scenarios: BAUD_DIV=4 (64 clk/bit), DATA_BITS=8, PARITY_MODE=1, STOP_BITS=1, FIFO_DEPTH=4.
- Good frame with echo: send 0x55, parity 1, stop 1, echo_en=1, cts_n=0 → rx_valid 1 pulse, rx_data=0x55, both errors 0; txd emits 0,10101010,1,1; idle returns to 1.
- Parity error: send 0xA3 with parity 0 (odd requires 1) → dataerror=1, framerror=0, rx_valid pulses, fifo_count stays 0, txd stays 1.
- Frame error: send 0x0F with stop=0 → framerror=1, no push; a following good 0x0F is received and echoed normally.
- False start and reset: rxd low for 16 clk (<half bit) → no rx_valid, state back to idle. Separately, assert rst=0 mid-TX data bit → txd=1 and idle=1 immediately.
- Overflow and flow control: cts_n=1, send 5 good frames 0x01..0x05 → fifo_count=4, overflow pulses once on 0x05. Then cts_n=0 → txd echoes 0x01..0x04 back-to-back and fifo_count decrements to 0.
